// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the TX and future RX blocks
// Purpose: FSM state encoding and parity mode constants.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - baud divider producing one tick per line bit
// Purpose: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   clear    in  synchronous clear; holds the counter at 0 and masks the tick
//   bit_tick out high in the last cycle of each line bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1, LAST is 0 and every non-cleared cycle ticks.
  assign bit_tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - serial frame transmitter with valid/ready handshake
// Purpose: sends start, DATA_W data bits, INSTR_W instruction bits (LSB first),
//   optional parity and STOP_BITS stop bits on an idle-high line.
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   tx_valid    in  frame request, accepted when tx_valid && tx_ready
//   tx_ready    out high only while idle
//   dado        in  data field, sampled on accept
//   instrucao   in  instruction field, sampled on accept (unused when INSTR_W=0)
//   info_saida  out registered serial line, idle 1
//   busy        out high while a frame is on the line
//   done        out one-cycle pulse after the last stop bit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int INSTR_W      = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic [DATA_W-1:0]                  dado,
  input  logic [(INSTR_W > 0 ? INSTR_W : 1)-1:0] instrucao,
  output logic                               info_saida,
  output logic                               busy,
  output logic                               done
);

  localparam int PW  = DATA_W + INSTR_W;
  localparam int BCW = $clog2(PW + 1);

  if (DATA_W < 1 || INSTR_W < 0 || CLKS_PER_BIT < 1 || PARITY_MODE < 0 ||
      PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter combination");
  end

  // Payload is sent from bit 0 upward, so data sits in the low bits.
  logic [PW-1:0] payload_in;
  if (INSTR_W > 0) begin : g_instr
    assign payload_in = {instrucao, dado};
  end else begin : g_no_instr
    logic unused_instr;
    assign unused_instr = ^instrucao;
    assign payload_in   = dado;
  end

  logic par_in;
  assign par_in = (PARITY_MODE == PARITY_ODD) ? ~(^payload_in) : ^payload_in;

  uart_state_t    state, state_n;
  logic [PW-1:0]  shreg, shreg_n;
  logic [BCW-1:0] bit_cnt, bit_cnt_n;
  logic           stop_cnt, stop_cnt_n;
  logic           par_bit, par_n;
  logic           line_n;
  logic           done_n;
  logic           bit_tick;

  // Held in clear while idle so the first bit after accept gets a full period.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .bit_tick (bit_tick)
  );

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_n      = par_bit;
    done_n     = 1'b0;
    line_n     = 1'b1;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n    = START;
          shreg_n    = payload_in;
          par_n      = par_in;
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
        end
      end
      START: begin
        if (bit_tick) state_n = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == BCW'(PW - 1)) begin
            state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            shreg_n   = shreg >> 1;
            bit_cnt_n = bit_cnt + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_n = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line value is decided from the next state so the output can be registered
    // without adding a cycle of latency.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shreg_n[0];
      PARITY:  line_n = par_n;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      par_bit    <= 1'b0;
      info_saida <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      stop_cnt   <= stop_cnt_n;
      par_bit    <= par_n;
      info_saida <= line_n;
      done       <= done_n;
    end
  end

endmodule
